// File: rtl/idea_b_checker.sv
// idea_b_checker: receive-side monitor for the IdeaB 14..5 down-counter.
// It predicts the next sample, locks after enough correct steps, flags sequence breaks and counts them.
module idea_b_checker #(
  parameter int WIDTH      = 4,
  parameter int HI         = 14,
  parameter int LO         = 5,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] val_in,
  input  logic             clr,
  output logic             lock,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] exp,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'b00, SYNC = 2'b01, LOCKED = 2'b10} state_t;
  localparam logic [WIDTH-1:0] hi_v = WIDTH'(HI);
  localparam logic [WIDTH-1:0] lo_v = WIDTH'(LO);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d, exp_d;
  logic [2:0]       good_q, good_d;
  logic [3:0]       good_inc;
  logic             err_d, wrap_d, legal, hit, locking;
  logic [ERR_W-1:0] cnt_base, cnt_d;
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
    return v == lo_v ? hi_v : v - 1'b1;
  endfunction
  assign legal    = val_in >= lo_v && val_in <= hi_v;
  assign hit      = val_in == nxt(ref_q);
  assign good_inc = {1'b0, good_q} + 4'd1;
  assign locking  = good_inc >= 4'(LOCK_COUNT);
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: if (ce && legal) begin
        state_d = SYNC;
        ref_d   = val_in;
        good_d  = '0;
      end
      SYNC: if (ce) begin
        ref_d   = val_in;
        state_d = !legal ? IDLE : (hit && locking) ? LOCKED : SYNC;
        good_d  = (legal && hit && !locking) ? good_inc[2:0] : '0;
      end
      LOCKED: if (ce) begin
        ref_d   = val_in;
        wrap_d  = hit && ref_q == lo_v;
        err_d   = !hit;
        state_d = hit ? LOCKED : legal ? SYNC : IDLE;
        good_d  = '0;
      end
      default: begin
        state_d = IDLE;
        ref_d   = '0;
        good_d  = '0;
      end
    endcase
    exp_d = state_d == IDLE ? '0 : nxt(ref_d);
  end
  // clear first, then count, so a clear coinciding with an error leaves 1
  assign cnt_base = clr ? '0 : err_cnt;
  assign cnt_d    = (err_d && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ref_q   <= '0;
      good_q  <= '0;
      exp     <= '0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      good_q  <= good_d;
      exp     <= exp_d;
      err     <= err_d;
      wrap    <= wrap_d;
      err_cnt <= cnt_d;
    end
  assign lock  = state_q == LOCKED;
  assign state = state_q;
endmodule
